// File: rtl/spi_burst_memory.sv
// rtl/spi_burst_memory.sv - SPI mode-0 slave fronting a word-addressed memory
//
// Purpose: a frame (cs low) carries ADDR_W address bits, one R/W bit (1 = read)
// and then data words, MSB first. All SPI pins are synchronised into clk and
// the SPI clock edges are detected as single-cycle events.
// Optional feature macro: SPI_MEM_BURST_EN. When it is defined, each frame
// carries unlimited words with an auto-incrementing address. When it is not
// defined, each frame carries a single word and then sits in HOLD.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk_pin   SPI clock (asynchronous)
//   cs_pin     SPI chip select, active-low (asynchronous)
//   mosi_pin   SPI master-out data (asynchronous)
//   miso_pin   SPI master-in data, forced 0 while miso_oe is low
//   miso_oe    high while a read word is being driven
//   busy       high while a frame is in progress
//   word_count data words completed in the current frame, saturating at 255
module spi_burst_memory #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic [7:0] word_count
);

`ifdef SPI_MEM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ, ST_HOLD} state_t;

  state_t              r_state, w_next;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic                r_cs_s1, r_cs_s2, r_cs_s3;
  logic                r_mosi_s1, r_mosi_s2;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_word_count;
  logic                r_load;
  logic                r_wr_pend;
  logic                r_miso;
  logic                r_oe;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic                w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic                w_last_addr, w_last_data, w_rd_done;
  logic [7:0]          w_wc_inc;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
  assign w_last_addr = (r_cnt == CNT_W'(ADDR_W));
  assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
  // cs rising in the same cycle as the last read bit wins, so the word does not count
  assign w_rd_done   = (r_state == ST_READ) & w_sclk_rise & w_last_data & ~w_cs_rise;
  assign w_wc_inc    = (r_word_count == 8'hFF) ? 8'hFF : r_word_count + 8'd1;

  // Synchronisers; the third sclk/cs stage exists only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk_pin;  r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs_pin;    r_cs_s2   <= r_cs_s1;   r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi_pin;  r_mosi_s2 <= r_mosi_s1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; cs rising overrides everything
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_cs_fall) w_next = ST_CMD;
        ST_CMD:   if (w_sclk_rise && w_last_addr) w_next = r_mosi_s2 ? ST_READ : ST_WRITE;
        ST_WRITE: if (r_wr_pend && !BURST) w_next = ST_HOLD;
        ST_READ:  if (w_rd_done && !BURST) w_next = ST_HOLD;
        ST_HOLD:  w_next = ST_HOLD;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy       = (r_state != ST_IDLE);
    miso_oe    = r_oe & (r_state == ST_READ);
    miso_pin   = r_oe & (r_state == ST_READ) & r_miso;
    word_count = r_word_count;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word_count <= 8'd0;
      r_load       <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_miso       <= 1'b0;
      r_oe         <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
      // A completed write word is committed one cycle after its last bit
      if (r_wr_pend) begin
        r_word_count <= w_wc_inc;
        if (BURST) r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_cs_rise) begin
        r_cnt  <= '0;
        r_load <= 1'b0;
        r_oe   <= 1'b0;
        r_miso <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_word_count <= 8'd0;
              r_cnt        <= '0;
              r_addr       <= '0;
              r_shift      <= '0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              if (w_last_addr) begin
                r_cnt  <= '0;
                r_load <= r_mosi_s2;
              end else begin
                r_addr <= {r_addr[ADDR_W-2:0], r_mosi_s2};
                r_cnt  <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_WRITE: begin
            if (w_sclk_rise) begin
              r_shift <= {r_shift[DATA_W-2:0], r_mosi_s2};
              if (w_last_data) begin
                r_cnt     <= '0;
                r_wr_pend <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_READ: begin
            if (r_load) begin
              r_shift <= r_mem[r_addr];
              r_load  <= 1'b0;
            end else if (w_sclk_fall) begin
              r_miso  <= r_shift[DATA_W-1];
              r_shift <= {r_shift[DATA_W-2:0], 1'b0};
              r_oe    <= 1'b1;
            end
            if (w_sclk_rise) begin
              if (w_last_data) begin
                r_cnt        <= '0;
                r_word_count <= w_wc_inc;
                if (BURST) begin
                  r_addr <= r_addr + ADDR_W'(1);
                  r_load <= 1'b1;
                end else begin
                  r_oe   <= 1'b0;
                  r_miso <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_oe   <= 1'b0;
            r_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  // Memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (r_wr_pend) r_mem[r_addr] <= r_shift;
  end

endmodule

// File: tb/tb_spi_burst_memory.sv
// tb/tb_spi_burst_memory.sv - directed self-checking bench for spi_burst_memory
module tb_spi_burst_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;
  logic       miso_oe;
  logic       busy;
  logic [7:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  spi_burst_memory #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_pin   (sclk_pin),
    .cs_pin     (cs_pin),
    .mosi_pin   (mosi_pin),
    .miso_pin   (miso_pin),
    .miso_oe    (miso_oe),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit: mosi set at the falling edge, miso sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic q);
    mosi_pin = b;
    tick(6);
    q = miso_pin;
    sclk_pin = 1'b1;
    tick(6);
    sclk_pin = 1'b0;
  endtask

  task automatic frame_begin();
    cs_pin = 1'b0;
    tick(6);
  endtask

  // Raise cs and confirm busy drops exactly on the third clk edge
  task automatic frame_end(input string tag);
    tick(4);
    cs_pin = 1'b1;
    tick(2);
    chk({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
    tick(1);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    tick(3);
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw);
    logic b;
    for (int i = 6; i >= 0; i--) spi_bit(a[i], b);
    spi_bit(rw, b);
  endtask

  task automatic xfer_byte(input logic [7:0] d, output logic [7:0] q);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], b);
      q[i] = b;
    end
  endtask

  task automatic write_word(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] q;
    frame_begin();
    send_cmd(a, 1'b0);
    xfer_byte(d, q);
    frame_end("wr");
  endtask

  task automatic read_word(input logic [6:0] a, output logic [7:0] q, output logic [7:0] wc);
    frame_begin();
    send_cmd(a, 1'b1);
    xfer_byte(8'h00, q);
    wc = word_count;
    frame_end("rd");
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] q2;
    logic [7:0] wc;
    logic [7:0] d;
    logic       b;

    rst_n    = 1'b0;
    cs_pin   = 1'b1;
    sclk_pin = 1'b0;
    mosi_pin = 1'b0;
    tick(3);
    chk("rst_miso", {31'd0, miso_pin}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wc", {24'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Single write then read back at 0x05
    frame_begin();
    chk("busy_rise", {31'd0, busy}, 32'd1);
    send_cmd(7'h05, 1'b0);
    xfer_byte(8'hA5, q);
    chk("wr05_wc", {24'd0, word_count}, 32'd1);
    frame_end("wr05");
    frame_begin();
    send_cmd(7'h05, 1'b1);
    xfer_byte(8'h00, q);
    chk("rd05_data", {24'd0, q}, 32'hA5);
    chk("rd05_wc", {24'd0, word_count}, 32'd1);
    frame_end("rd05");
    chk("idle_oe", {31'd0, miso_oe}, 32'd0);
    chk("idle_miso", {31'd0, miso_pin}, 32'd0);

    // Partial write word is discarded
    write_word(7'h10, 8'h81);
    frame_begin();
    send_cmd(7'h10, 1'b0);
    d = 8'h3C;
    for (int i = 7; i >= 3; i--) spi_bit(d[i], b);
    frame_end("partial");
    read_word(7'h10, q, wc);
    chk("partial_rd", {24'd0, q}, 32'h81);

    // cs rising coincides with the last data-bit rise: word discarded
    write_word(7'h30, 8'h12);
    frame_begin();
    send_cmd(7'h30, 1'b0);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, b);
    mosi_pin = 1'b1;
    tick(6);
    sclk_pin = 1'b1;
    cs_pin   = 1'b1;
    tick(6);
    sclk_pin = 1'b0;
    chk("race_busy", {31'd0, busy}, 32'd0);
    tick(3);
    read_word(7'h30, q, wc);
    chk("race_rd", {24'd0, q}, 32'h12);

    // Partial command has no effect; word_count cleared by the new frame
    frame_begin();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    frame_end("pcmd");
    chk("pcmd_wc", {24'd0, word_count}, 32'd0);
    read_word(7'h05, q, wc);
    chk("pcmd_rd05", {24'd0, q}, 32'hA5);

    // Reset in the middle of a read
    frame_begin();
    send_cmd(7'h05, 1'b1);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    chk("mid_oe", {31'd0, miso_oe}, 32'd1);
    chk("mid_miso", {31'd0, miso_pin}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_miso", {31'd0, miso_pin}, 32'd0);
    chk("arst_oe", {31'd0, miso_oe}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    cs_pin = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    read_word(7'h05, q, wc);
    chk("post_rst_rd05", {24'd0, q}, 32'hA5);

`ifdef SPI_MEM_BURST_EN
    // Burst across the address wrap
    frame_begin();
    send_cmd(7'h7F, 1'b0);
    xfer_byte(8'h11, q);
    xfer_byte(8'h22, q);
    chk("bwr_wc", {24'd0, word_count}, 32'd2);
    frame_end("bwr");
    frame_begin();
    send_cmd(7'h7F, 1'b1);
    xfer_byte(8'h00, q);
    xfer_byte(8'h00, q2);
    chk("brd_w0", {24'd0, q}, 32'h11);
    chk("brd_w1", {24'd0, q2}, 32'h22);
    chk("brd_wc", {24'd0, word_count}, 32'd2);
    frame_end("brd");
    read_word(7'h00, q, wc);
    chk("brd_00", {24'd0, q}, 32'h22);
`else
    // Single-word frames: second word ignored in HOLD
    write_word(7'h21, 8'h99);
    frame_begin();
    send_cmd(7'h20, 1'b0);
    xfer_byte(8'h55, q);
    xfer_byte(8'h66, q);
    chk("nb_wr_wc", {24'd0, word_count}, 32'd1);
    frame_end("nbwr");
    frame_begin();
    send_cmd(7'h20, 1'b1);
    xfer_byte(8'h00, q);
    xfer_byte(8'h00, q2);
    chk("nb_rd_w0", {24'd0, q}, 32'h55);
    chk("nb_rd_w1", {24'd0, q2}, 32'h00);
    chk("nb_hold_oe", {31'd0, miso_oe}, 32'd0);
    chk("nb_rd_wc", {24'd0, word_count}, 32'd1);
    frame_end("nbrd");
    read_word(7'h21, q, wc);
    chk("nb_rd21", {24'd0, q}, 32'h99);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
